// File: rtl/lcd_rgb_pkg.sv
// rtl/lcd_rgb_pkg.sv - shared state type, geometry defaults and counter helpers for lcd_rgb_capture
package lcd_rgb_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_VBLANK  = 2'd1,
    ST_LINE    = 2'd2,
    ST_HBLANK  = 2'd3
  } cap_state_t;

  localparam int HW_H_ACTIVE  = 480;
  localparam int HW_V_ACTIVE  = 272;
  localparam int SIM_H_ACTIVE = 64;
  localparam int SIM_V_ACTIVE = 32;
  localparam int DEF_TIMEOUT  = 1024;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lcd_rgb_sync_edge.sv
// rtl/lcd_rgb_sync_edge.sv - 2-flop synchronizer for the panel bus plus dclk rising-edge strobe
module lcd_rgb_sync_edge #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_dclk,
  input  logic [WIDTH-1:0] i_bus,
  output logic [WIDTH-1:0] o_bus,
  output logic             o_dclk_rise
);

  logic [WIDTH-1:0] r_bus_s1;
  logic [WIDTH-1:0] r_bus_s2;
  logic             r_dclk_s1;
  logic             r_dclk_s2;
  logic             r_dclk_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_s1  <= '0;
      r_bus_s2  <= '0;
      r_dclk_s1 <= 1'b0;
      r_dclk_s2 <= 1'b0;
      r_dclk_s3 <= 1'b0;
    end else begin
      r_bus_s1  <= i_bus;
      r_bus_s2  <= r_bus_s1;
      r_dclk_s1 <= i_dclk;
      r_dclk_s2 <= r_dclk_s1;
      r_dclk_s3 <= r_dclk_s2;
    end
  end

  // Bus is taken at s2 in the same cycle the edge is seen; it settled half a dclk earlier.
  assign o_bus       = r_bus_s2;
  assign o_dclk_rise = r_dclk_s2 & ~r_dclk_s3;

endmodule

// File: rtl/lcd_rgb_capture.sv
// rtl/lcd_rgb_capture.sv - DE-mode RGB receiver: pixel stream with coordinates, geometry measurement, link lock
module lcd_rgb_capture
  import lcd_rgb_pkg::*;
#(
  parameter int H_ACTIVE = HW_H_ACTIVE,
  parameter int V_ACTIVE = HW_V_ACTIVE,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           lcd_dclk,
  input  logic           lcd_de,
  input  logic           lcd_hsync,
  input  logic           lcd_vsync,
  input  logic [7:0]     lcd_red,
  input  logic [7:0]     lcd_green,
  input  logic [7:0]     lcd_blue,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [23:0]    pix_rgb,
  output logic           pix_sof,
  output logic           pix_eol,
  output logic           frame_done,
  output logic [X_W-1:0] meas_width,
  output logic [Y_W-1:0] meas_height,
  output logic           line_err,
  output logic           frame_err,
  output logic [15:0]    frame_count,
  output logic           locked
);

  localparam int             TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [X_W-1:0] H_LIM   = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_LIM   = Y_W'(V_ACTIVE);

  logic [26:0]    w_sync_bus;
  logic           w_rise;
  logic           w_de;
  logic           w_unused_hsync;
  logic           w_vsync;
  logic [23:0]    w_rgb;
  logic           w_boundary;
  logic           w_in_line;
  logic           w_line_close;
  logic           w_pix_take;
  logic           w_pix_ok;
  logic [X_W-1:0] w_pix_x;
  logic [Y_W-1:0] w_y_inc;
  logic [Y_W-1:0] w_height;

  cap_state_t      r_state;
  logic            r_vs_prev;
  logic [X_W-1:0]  r_x;
  logic [Y_W-1:0]  r_y;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_pix_valid;
  logic [X_W-1:0]  r_pix_x;
  logic [Y_W-1:0]  r_pix_y;
  logic [23:0]     r_pix_rgb;
  logic            r_pix_sof;
  logic            r_pix_eol;
  logic            r_frame_done;
  logic [X_W-1:0]  r_meas_width;
  logic [Y_W-1:0]  r_meas_height;
  logic            r_line_err;
  logic            r_frame_err;
  logic [15:0]     r_frame_count;
  logic            r_locked;

  lcd_rgb_sync_edge #(.WIDTH(27)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_dclk      (lcd_dclk),
    .i_bus       ({lcd_de, lcd_hsync, lcd_vsync, lcd_red, lcd_green, lcd_blue}),
    .o_bus       (w_sync_bus),
    .o_dclk_rise (w_rise)
  );

  assign w_de           = w_sync_bus[26];
  assign w_unused_hsync = w_sync_bus[25];
  assign w_vsync        = w_sync_bus[24];
  assign w_rgb          = w_sync_bus[23:0];

  assign w_boundary   = r_vs_prev & ~w_vsync;
  assign w_in_line    = (r_state == ST_LINE);
  assign w_line_close = w_in_line & (w_boundary | ~w_de);
  assign w_pix_take   = w_de & (w_in_line | w_vsync);
  // The line-opening edge is itself pixel 0, so x is forced to zero outside LINE.
  assign w_pix_x      = w_in_line ? r_x : '0;
  assign w_pix_ok     = (w_pix_x < H_LIM) & (r_y < V_LIM);
  assign w_y_inc      = sat_inc_y(r_y);
  assign w_height     = w_in_line ? w_y_inc : r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_WAIT_VS;
      r_vs_prev     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_to_cnt      <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_rgb     <= '0;
      r_pix_sof     <= 1'b0;
      r_pix_eol     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_meas_width  <= '0;
      r_meas_height <= '0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
      r_locked      <= 1'b0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_pix_sof    <= 1'b0;
      r_pix_eol    <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_rise) begin
        r_to_cnt  <= '0;
        r_vs_prev <= w_vsync;
        if (r_state == ST_WAIT_VS) begin
          if (w_boundary) begin
            r_locked <= 1'b1;
            r_x      <= '0;
            r_y      <= '0;
            r_state  <= ST_VBLANK;
          end
        end else begin
          if (w_line_close) begin
            r_meas_width <= r_x;
            r_line_err   <= (r_x != H_LIM);
            r_x          <= '0;
            r_y          <= w_y_inc;
          end
          // A boundary inside LINE closes the line above and ends the frame on the same edge.
          if (w_boundary) begin
            r_meas_height <= w_height;
            r_frame_err   <= (w_height != V_LIM);
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 1'b1;
            r_y           <= '0;
            r_state       <= ST_VBLANK;
          end else if (w_line_close) begin
            r_state <= ST_HBLANK;
          end else if (w_pix_take) begin
            r_pix_valid <= w_pix_ok;
            r_pix_x     <= w_pix_x;
            r_pix_y     <= r_y;
            r_pix_rgb   <= w_rgb;
            r_pix_sof   <= w_pix_ok & (w_pix_x == '0) & (r_y == '0);
            r_pix_eol   <= w_pix_ok & (w_pix_x == H_LAST);
            r_x         <= sat_inc_x(w_pix_x);
            r_state     <= ST_LINE;
          end
        end
      end else if (r_to_cnt == TO_LAST) begin
        r_state   <= ST_WAIT_VS;
        r_locked  <= 1'b0;
        r_x       <= '0;
        r_y       <= '0;
        r_vs_prev <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_rgb     = r_pix_rgb;
  assign pix_sof     = r_pix_sof;
  assign pix_eol     = r_pix_eol;
  assign frame_done  = r_frame_done;
  assign meas_width  = r_meas_width;
  assign meas_height = r_meas_height;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;
  assign locked      = r_locked;

endmodule

// File: tb/tb_lcd_rgb_capture.sv
// tb/tb_lcd_rgb_capture.sv - randomized panel-stream bench for lcd_rgb_capture with a frame-level scoreboard
`timescale 1ns/1ps
module tb_lcd_rgb_capture;

  localparam int H       = 64;
  localparam int V       = 32;
  localparam int H_TOT   = 69;
  localparam int V_BLANK = 3;
  localparam int TO      = 1024;
  localparam int NONE    = 999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_dclk = 1'b0;
  logic        lcd_de = 1'b0;
  logic        lcd_hsync = 1'b0;
  logic        lcd_vsync = 1'b0;
  logic [7:0]  lcd_red = '0;
  logic [7:0]  lcd_green = '0;
  logic [7:0]  lcd_blue = '0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        pix_sof;
  logic        pix_eol;
  logic        frame_done;
  logic [9:0]  meas_width;
  logic [8:0]  meas_height;
  logic        line_err;
  logic        frame_err;
  logic [15:0] frame_count;
  logic        locked;

  always #5 clk = ~clk;

  lcd_rgb_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_dclk(lcd_dclk), .lcd_de(lcd_de),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_red(lcd_red),
    .lcd_green(lcd_green), .lcd_blue(lcd_blue), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .frame_done(frame_done), .meas_width(meas_width),
    .meas_height(meas_height), .line_err(line_err), .frame_err(frame_err),
    .frame_count(frame_count), .locked(locked)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [127:0] q_pix[$];
  logic [127:0] q_line[$];
  logic [127:0] q_frame[$];
  bit          m_locked = 0;
  int          m_lines = 0;
  int          m_last_w = 0;
  logic [15:0] m_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every pulse must match the next expectation, including its clk cycle.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (q_pix.size() == 0) chk("pix_unexp", 128'({cyc, pix_x, pix_y, pix_rgb, pix_sof, pix_eol}), '0);
      else chk("pix", 128'({cyc, pix_x, pix_y, pix_rgb, pix_sof, pix_eol}), q_pix.pop_front());
    end else if (pix_sof | pix_eol) begin
      chk("flag_no_valid", 128'({pix_sof, pix_eol}), '0);
    end
    if (line_err) begin
      if (q_line.size() == 0) chk("line_unexp", 128'({cyc, meas_width}), '0);
      else chk("line_err", 128'({cyc, meas_width}), q_line.pop_front());
    end
    if (frame_done | frame_err) begin
      if (q_frame.size() == 0)
        chk("frame_unexp", 128'({cyc, frame_done, frame_err, meas_height, meas_width, frame_count}), '0);
      else
        chk("frame", 128'({cyc, frame_done, frame_err, meas_height, meas_width, frame_count}), q_frame.pop_front());
    end
  end

  // One dclk period; returns at the rising edge so expectations are queued before the DUT reacts.
  task automatic send_edge(input logic de, input logic vs, input logic [23:0] rgb, output int unsigned t);
    repeat (4) @(negedge clk);
    lcd_dclk  = 1'b0;
    lcd_de    = de;
    lcd_vsync = vs;
    lcd_hsync = ~de & vs;
    {lcd_red, lcd_green, lcd_blue} = rgb;
    repeat (4) @(negedge clk);
    lcd_dclk = 1'b1;
    t = cyc;
  endtask

  task automatic preamble();
    int unsigned t;
    for (int i = 0; i < 4; i++) send_edge(1'b0, 1'b1, 24'h0, t);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  // Frame: 2 vsync-low lines, 1 blank line, n_act active lines of H_TOT dclks each.
  task automatic send_frame(input int n_act, input int short_row, input int short_w,
                            input bit ramp, input int stop_row, input int stop_x);
    int unsigned t;
    logic [23:0] rgb;
    int w, r;
    for (int ln = 0; ln < V_BLANK + n_act; ln++) begin
      r = ln - V_BLANK;
      w = (r < 0) ? 0 : ((r == short_row) ? short_w : H);
      for (int d = 0; d < H_TOT; d++) begin
        if (r == stop_row && d == stop_x) return;
        rgb = ramp ? {8'(d), 8'(r), 8'(d ^ r)} : 24'($urandom);
        send_edge(d < w, ln >= 2, rgb, t);
        if (ln == 0 && d == 0) begin
          if (m_locked) begin
            q_frame.push_back(128'({32'(t + 3), 1'b1, 1'(m_lines != V), 9'(m_lines),
                                    10'(m_last_w), 16'(m_count + 16'd1)}));
            m_count++;
          end else begin
            m_locked = 1;
          end
          m_lines = 0;
        end
        if (m_locked && d < w && d < H && r < V)
          q_pix.push_back(128'({32'(t + 3), 10'(d), 9'(r), rgb, 1'(d == 0 && r == 0), 1'(d == H - 1)}));
        if (m_locked && w > 0 && d == w) begin
          m_last_w = w;
          m_lines++;
          if (w != H) q_line.push_back(128'({32'(t + 3), 10'(w)}));
        end
      end
    end
  endtask

  initial begin
    int unsigned t;
    repeat (3) @(negedge clk);
    chk("reset_outs", 128'({pix_valid, pix_x, pix_y, pix_rgb, pix_sof, pix_eol, frame_done, meas_width,
                            meas_height, line_err, frame_err, frame_count, locked}), '0);
    rst_n = 1'b1;
    preamble();
    chk("locked_before_boundary", 128'(locked), 128'(0));

    send_frame(V, NONE, 0, 1'b1, NONE, 0);
    chk("locked_after_first", 128'(locked), 128'(1));
    chk("fcount_first", 128'(frame_count), 128'(0));

    send_frame(V, int'($urandom_range(0, V - 1)), 60, 1'b0, NONE, 0);
    send_frame(V + 2, NONE, 0, 1'b0, NONE, 0);
    send_frame(V, NONE, 0, 1'b0, 5, 20);
    drain();
    chk("fcount_three", 128'(frame_count), 128'(3));
    chk("height_long", 128'(meas_height), 128'(V + 2));

    repeat (TO + 1) @(negedge clk);
    chk("locked_timeout", 128'(locked), 128'(0));
    m_locked = 0;

    preamble();
    send_frame(V, NONE, 0, 1'b1, 3, 30);
    drain();
    chk("locked_relock", 128'(locked), 128'(1));
    chk("fcount_relock", 128'(frame_count), 128'(3));

    rst_n = 1'b0;
    m_locked = 0;
    m_count = '0;
    @(negedge clk);
    chk("reset_mid", 128'({pix_valid, pix_x, pix_y, pix_rgb, pix_sof, pix_eol, frame_done, meas_width,
                           meas_height, line_err, frame_err, frame_count, locked}), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_edge(1'b1, 1'b1, 24'($urandom), t);
    drain();
    chk("locked_post_reset", 128'(locked), 128'(0));

    preamble();
    send_frame(V, NONE, 0, 1'b1, 2, 10);
    drain();
    chk("locked_final", 128'(locked), 128'(1));
    chk("fcount_restart", 128'(frame_count), 128'(0));
    chk("pix_left", 128'(q_pix.size()), 128'(0));
    chk("line_left", 128'(q_line.size()), 128'(0));
    chk("frame_left", 128'(q_frame.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
